// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dm_arb_pkg;

  // Default number of extra memory wait states per access.
  localparam int unsigned WAIT_CYCLES_DEF = 0;

  // Width of the wait-state counter (covers 0..3).
  localparam int unsigned CNT_W = 2;

  // Arbiter FSM states.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Owner of the access in progress.
  typedef enum logic [0:0] {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

  // A word access is aligned when the two low address bits are zero.
  function automatic logic is_aligned(input logic [1:0] addr_lo);
    return (addr_lo == 2'b00);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin pick. On a tie the requester that did not
// own the previous access wins. Purely combinational.
module rr_arb2
  import dm_arb_pkg::*;
(
  input  logic req_a_i,       // CPU request (already qualified)
  input  logic req_b_i,       // debug request (already qualified)
  input  logic last_owner_i,  // 0 = CPU, 1 = DBG
  output logic valid_o,       // at least one requester present
  output logic winner_o       // 0 = CPU, 1 = DBG
);

  // Select the winner from the qualified requests and the last owner.
  always_comb begin
    valid_o  = req_a_i | req_b_i;
    winner_o = 1'b0;
    if (req_a_i && req_b_i) begin
      winner_o = (last_owner_i == OWN_CPU) ? 1'b1 : 1'b0;
    end else if (req_b_i) begin
      winner_o = 1'b1;
    end else begin
      winner_o = 1'b0;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Data-memory arbiter between the CPU MEM stage and a debug/loader port.
// One access at a time: IDLE grants and latches a request, BUSY waits
// WAIT_CYCLES extra cycles, performs the memory access and pulses the
// owner's ready. Misaligned accesses complete with err set, no write and
// zero read data.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ready,
  output logic [31:0] dbg_rdata,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_we,
  input  logic [31:0] dm_rdata,
  output logic        err
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = WAIT_CYCLES[CNT_W-1:0];

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  owner_e           owner_q, owner_d;
  owner_e           last_owner_q, last_owner_d;
  logic             lat_we_q, lat_we_d;
  logic [31:0]      lat_addr_q, lat_addr_d;
  logic [31:0]      lat_wdata_q, lat_wdata_d;
  logic             cpu_ready_q, cpu_ready_d;
  logic             dbg_ready_q, dbg_ready_d;
  logic             err_q, err_d;
  logic [31:0]      cpu_rdata_q, cpu_rdata_d;
  logic [31:0]      dbg_rdata_q, dbg_rdata_d;

  logic             cpu_elig_s;
  logic             dbg_elig_s;
  logic             grant_valid_s;
  logic             winner_s;
  logic             busy_s;
  logic             aligned_s;
  logic             last_cycle_s;
  logic [31:0]      rd_cap_s;

  // A port that is seeing its ready pulse is ignored for that cycle.
  assign cpu_elig_s = cpu_req & ~cpu_ready_q;
  assign dbg_elig_s = dbg_req & ~dbg_ready_q;

  rr_arb2 u_rr_arb2 (
    .req_a_i      (cpu_elig_s),
    .req_b_i      (dbg_elig_s),
    .last_owner_i (last_owner_q),
    .valid_o      (grant_valid_s),
    .winner_o     (winner_s)
  );

  assign busy_s       = (state_q == BUSY);
  assign aligned_s    = is_aligned(lat_addr_q[1:0]);
  assign last_cycle_s = busy_s & (cnt_q == {CNT_W{1'b0}});
  assign rd_cap_s     = aligned_s ? dm_rdata : 32'd0;

  // Memory-side outputs come only from latched state, so they drop at once on reset.
  assign dm_addr   = busy_s ? lat_addr_q  : 32'd0;
  assign dm_wdata  = busy_s ? lat_wdata_q : 32'd0;
  assign dm_we     = last_cycle_s & lat_we_q & aligned_s;

  assign cpu_ready = cpu_ready_q;
  assign dbg_ready = dbg_ready_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign err       = err_q;
  assign cpu_stall = cpu_req & ~cpu_ready_q;

  // Next-state logic: grant in IDLE, count wait states and complete in BUSY.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    lat_we_d     = lat_we_q;
    lat_addr_d   = lat_addr_q;
    lat_wdata_d  = lat_wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    cpu_ready_d  = 1'b0;
    dbg_ready_d  = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid_s) begin
          state_d = BUSY;
          cnt_d   = WAIT_LOAD;
          if (winner_s) begin
            owner_d     = OWN_DBG;
            lat_we_d    = dbg_we;
            lat_addr_d  = dbg_addr;
            lat_wdata_d = dbg_wdata;
          end else begin
            owner_d     = OWN_CPU;
            lat_we_d    = cpu_we;
            lat_addr_d  = cpu_addr;
            lat_wdata_d = cpu_wdata;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q != {CNT_W{1'b0}}) begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          state_d      = IDLE;
          last_owner_d = owner_q;
          err_d        = ~aligned_s;
          if (owner_q == OWN_DBG) begin
            dbg_ready_d = 1'b1;
            dbg_rdata_d = rd_cap_s;
          end else begin
            cpu_ready_d = 1'b1;
            cpu_rdata_d = rd_cap_s;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State registers; reset aborts any access in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      owner_q      <= OWN_CPU;
      last_owner_q <= OWN_DBG;
      lat_we_q     <= 1'b0;
      lat_addr_q   <= 32'd0;
      lat_wdata_q  <= 32'd0;
      cpu_ready_q  <= 1'b0;
      dbg_ready_q  <= 1'b0;
      err_q        <= 1'b0;
      cpu_rdata_q  <= 32'd0;
      dbg_rdata_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      lat_we_q     <= lat_we_d;
      lat_addr_q   <= lat_addr_d;
      lat_wdata_q  <= lat_wdata_d;
      cpu_ready_q  <= cpu_ready_d;
      dbg_ready_q  <= dbg_ready_d;
      err_q        <= err_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: three instances (WAIT_CYCLES 0, 2, 3), each with
// its own 64-word memory. Table-driven single accesses, directed corner
// sequences, and a randomized run against a transaction-level model.
module tb_dm_arbiter;

  localparam int NI = 3;   // instance 0: W=0, 1: W=2, 2: W=3

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [NI];
  logic        cpu_req   [NI];
  logic        cpu_we    [NI];
  logic [31:0] cpu_addr  [NI];
  logic [31:0] cpu_wdata [NI];
  logic        cpu_ready [NI];
  logic [31:0] cpu_rdata [NI];
  logic        cpu_stall [NI];
  logic        dbg_req   [NI];
  logic        dbg_we    [NI];
  logic [31:0] dbg_addr  [NI];
  logic [31:0] dbg_wdata [NI];
  logic        dbg_ready [NI];
  logic [31:0] dbg_rdata [NI];
  logic [31:0] dm_addr   [NI];
  logic [31:0] dm_wdata  [NI];
  logic        dm_we     [NI];
  logic [31:0] dm_rdata  [NI];
  logic        err       [NI];

  logic [31:0] mem [NI][64];
  logic        clr_mem;
  int          we_cnt [NI];

  int checks = 0;
  int errors = 0;

  genvar g;
  generate
    for (g = 0; g < NI; g++) begin : g_dut
      localparam int unsigned W = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
      dm_arbiter #(.WAIT_CYCLES(W)) u_dut (
        .clk       (clk),
        .rst       (rst[g]),
        .cpu_req   (cpu_req[g]),
        .cpu_we    (cpu_we[g]),
        .cpu_addr  (cpu_addr[g]),
        .cpu_wdata (cpu_wdata[g]),
        .cpu_ready (cpu_ready[g]),
        .cpu_rdata (cpu_rdata[g]),
        .cpu_stall (cpu_stall[g]),
        .dbg_req   (dbg_req[g]),
        .dbg_we    (dbg_we[g]),
        .dbg_addr  (dbg_addr[g]),
        .dbg_wdata (dbg_wdata[g]),
        .dbg_ready (dbg_ready[g]),
        .dbg_rdata (dbg_rdata[g]),
        .dm_addr   (dm_addr[g]),
        .dm_wdata  (dm_wdata[g]),
        .dm_we     (dm_we[g]),
        .dm_rdata  (dm_rdata[g]),
        .err       (err[g])
      );
    end
  endgenerate

  // Combinational memory read port for each instance.
  always_comb begin
    for (int k = 0; k < NI; k++) begin
      dm_rdata[k] = mem[k][dm_addr[k][7:2]];
    end
  end

  // Memory writes and write-strobe counting.
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (clr_mem) begin
        for (int j = 0; j < 64; j++) mem[k][j] <= 32'd0;
      end else if (dm_we[k]) begin
        mem[k][dm_addr[k][7:2]] <= dm_wdata[k];
      end
      if (dm_we[k]) we_cnt[k] <= we_cnt[k] + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One access on one port; returns latency in cycles (-1 on timeout).
  task automatic run_access(input int k, input bit port, input bit we,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output int lat, output logic [31:0] rd,
                            output logic e, output bit other);
    lat = -1; rd = 32'd0; e = 1'b0; other = 1'b0;
    if (!port) begin
      cpu_we[k] = we; cpu_addr[k] = addr; cpu_wdata[k] = wdata; cpu_req[k] = 1'b1;
    end else begin
      dbg_we[k] = we; dbg_addr[k] = addr; dbg_wdata[k] = wdata; dbg_req[k] = 1'b1;
    end
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (port ? cpu_ready[k] : dbg_ready[k]) other = 1'b1;
      if (port ? dbg_ready[k] : cpu_ready[k]) begin
        lat = n;
        rd  = port ? dbg_rdata[k] : cpu_rdata[k];
        e   = err[k];
        break;
      end
    end
    if (!port) cpu_req[k] = 1'b0; else dbg_req[k] = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    int          k;
    bit          port;     // 0 = CPU, 1 = DBG
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk_rd;
    logic [31:0] exp_rd;
    bit          exp_err;
    int          exp_lat;
    int          exp_wr;   // expected number of dm_we cycles
  } vec_t;

  vec_t tbl [11];

  // Reference model state for the randomized run (instance 1, W=2).
  bit          m_act, m_own, m_we, m_last, m_cr, m_dr, m_err;
  int          m_done, e_idx;
  logic [31:0] m_addr, m_wd, m_crd, m_drd;
  logic [31:0] mmem [64];

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        e;
    bit          other;
    int          wc0;
    int          n_done;

    clr_mem = 1'b1;
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b0; cpu_req[k] = 1'b0; cpu_we[k] = 1'b0; cpu_addr[k] = 32'd0; cpu_wdata[k] = 32'd0;
      dbg_req[k] = 1'b0; dbg_we[k] = 1'b0; dbg_addr[k] = 32'd0; dbg_wdata[k] = 32'd0;
    end
    @(posedge clk); @(posedge clk); #1;

    // Reset state.
    for (int k = 0; k < NI; k++) begin
      chk("rst_cpu_ready", 32'(cpu_ready[k]), 32'd0);
      chk("rst_dbg_ready", 32'(dbg_ready[k]), 32'd0);
      chk("rst_err",       32'(err[k]),       32'd0);
      chk("rst_dm_we",     32'(dm_we[k]),     32'd0);
      chk("rst_dm_addr",   dm_addr[k],        32'd0);
      chk("rst_cpu_rdata", cpu_rdata[k],      32'd0);
      chk("rst_dbg_rdata", dbg_rdata[k],      32'd0);
    end
    clr_mem = 1'b0;
    for (int k = 0; k < NI; k++) rst[k] = 1'b1;
    @(posedge clk); #1;

    // Tie after reset, both held: CPU, DBG, CPU, DBG.
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 32'h0;
    dbg_req[0] = 1'b1; dbg_we[0] = 1'b0; dbg_addr[0] = 32'h4;
    for (int c = 1; c <= 10; c++) begin
      bit ec, ed;
      @(posedge clk); #1;
      ec = (c == 2) || (c == 6) || (c == 10);
      ed = (c == 4) || (c == 8);
      chk("rr_cpu_ready", 32'(cpu_ready[0]), 32'(ec));
      chk("rr_dbg_ready", 32'(dbg_ready[0]), 32'(ed));
      chk("rr_cpu_stall", 32'(cpu_stall[0]), 32'(!ec));
      if (c == 8)  dbg_req[0] = 1'b0;
      if (c == 10) cpu_req[0] = 1'b0;
    end
    @(posedge clk); #1;

    // Table of single accesses.
    tbl[0]  = '{0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 2, 1};
    tbl[1]  = '{0, 1'b0, 1'b0, 32'h10, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 2, 0};
    tbl[2]  = '{0, 1'b0, 1'b1, 32'h13, 32'hCAFEF00D, 1'b0, 32'h0,        1'b1, 2, 0};
    tbl[3]  = '{0, 1'b0, 1'b0, 32'h10, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 2, 0};
    tbl[4]  = '{0, 1'b1, 1'b0, 32'h11, 32'h0,        1'b1, 32'h0,        1'b1, 2, 0};
    tbl[5]  = '{0, 1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0, 32'h0,        1'b0, 2, 1};
    tbl[6]  = '{0, 1'b0, 1'b0, 32'h20, 32'h0,        1'b1, 32'h12345678, 1'b0, 2, 0};
    tbl[7]  = '{2, 1'b1, 1'b1, 32'h20, 32'h0BADF00D, 1'b0, 32'h0,        1'b0, 5, 1};
    tbl[8]  = '{2, 1'b1, 1'b0, 32'h20, 32'h0,        1'b1, 32'h0BADF00D, 1'b0, 5, 0};
    tbl[9]  = '{1, 1'b0, 1'b1, 32'h30, 32'h11111111, 1'b0, 32'h0,        1'b0, 4, 1};
    tbl[10] = '{1, 1'b1, 1'b0, 32'h30, 32'h0,        1'b1, 32'h11111111, 1'b0, 4, 0};
    for (int i = 0; i < 11; i++) begin
      wc0 = we_cnt[tbl[i].k];
      run_access(tbl[i].k, tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, lat, rd, e, other);
      chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'(tbl[i].exp_lat));
      chk($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].exp_err));
      chk($sformatf("tbl%0d_writes", i), 32'(we_cnt[tbl[i].k] - wc0), 32'(tbl[i].exp_wr));
      chk($sformatf("tbl%0d_other_ready", i), 32'(other), 32'd0);
      if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
    end

    // Reset during the write cycle of an access (instance 1, W=2).
    wc0 = we_cnt[1];
    cpu_we[1] = 1'b1; cpu_addr[1] = 32'h30; cpu_wdata[1] = 32'h22222222; cpu_req[1] = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("abort_we_before", 32'(dm_we[1]), 32'd1);
    rst[1] = 1'b0; #1;
    chk("abort_we_now",    32'(dm_we[1]),     32'd0);
    chk("abort_ready",     32'(cpu_ready[1]), 32'd0);
    chk("abort_dbg_rdata", dbg_rdata[1],      32'd0);
    cpu_req[1] = 1'b0;
    @(posedge clk); #1;
    rst[1] = 1'b1;
    n_done = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (cpu_ready[1] || dbg_ready[1]) n_done++;
    end
    chk("abort_no_pulse",  32'(n_done), 32'd0);
    chk("abort_no_write",  32'(we_cnt[1] - wc0), 32'd0);
    run_access(1, 1'b0, 1'b0, 32'h30, 32'h0, lat, rd, e, other);
    chk("abort_next_latency", 32'(lat), 32'd4);
    chk("abort_mem_kept",     rd,       32'h11111111);

    // Address change mid-BUSY (instance 2, W=3).
    cpu_we[2] = 1'b1; cpu_addr[2] = 32'h40; cpu_wdata[2] = 32'h55AA55AA; cpu_req[2] = 1'b1;
    @(posedge clk); #1;
    cpu_addr[2] = 32'h44; cpu_wdata[2] = 32'hFFFFFFFF;
    n_done = 0;
    for (int n = 2; n <= 20; n++) begin
      @(posedge clk); #1;
      if (cpu_ready[2]) begin n_done = n; break; end
      chk("midbusy_dm_addr", dm_addr[2], 32'h40);
    end
    chk("midbusy_latency", 32'(n_done), 32'd5);
    cpu_req[2] = 1'b0;
    @(posedge clk); #1;
    run_access(2, 1'b0, 1'b0, 32'h40, 32'h0, lat, rd, e, other);
    chk("midbusy_orig", rd, 32'h55AA55AA);
    run_access(2, 1'b0, 1'b0, 32'h44, 32'h0, lat, rd, e, other);
    chk("midbusy_new_untouched", rd, 32'h0);

    // Randomized run on instance 1 against the transaction model.
    rst[1] = 1'b0; clr_mem = 1'b1;
    @(posedge clk); #1;
    clr_mem = 1'b0; rst[1] = 1'b1;
    @(posedge clk); #1;
    m_act = 1'b0; m_last = 1'b1; m_cr = 1'b0; m_dr = 1'b0; m_err = 1'b0;
    m_crd = 32'd0; m_drd = 32'd0; m_done = 0; e_idx = 0;
    m_own = 1'b0; m_we = 1'b0; m_addr = 32'd0; m_wd = 32'd0;
    for (int j = 0; j < 64; j++) mmem[j] = 32'd0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit          p_creq, p_cwe, p_dreq, p_dwe, pr, pd, ec, ed, mis;
      logic [31:0] p_cad, p_cwd, p_dad, p_dwd, val;
      p_creq = cpu_req[1]; p_cwe = cpu_we[1]; p_cad = cpu_addr[1]; p_cwd = cpu_wdata[1];
      p_dreq = dbg_req[1]; p_dwe = dbg_we[1]; p_dad = dbg_addr[1]; p_dwd = dbg_wdata[1];
      @(posedge clk); #1;
      e_idx++;
      pr = m_cr; pd = m_dr; m_cr = 1'b0; m_dr = 1'b0; m_err = 1'b0;
      if (m_act) begin
        if (e_idx == m_done) begin
          mis = (m_addr[1:0] != 2'b00);
          val = mis ? 32'd0 : mmem[m_addr[7:2]];
          if (m_own) begin m_dr = 1'b1; m_drd = val; end
          else       begin m_cr = 1'b1; m_crd = val; end
          m_err = mis;
          if (m_we && !mis) mmem[m_addr[7:2]] = m_wd;
          m_last = m_own;
          m_act  = 1'b0;
        end
      end else begin
        ec = p_creq && !pr;
        ed = p_dreq && !pd;
        if (ec || ed) begin
          m_own  = (ec && ed) ? !m_last : ed;
          m_we   = m_own ? p_dwe : p_cwe;
          m_addr = m_own ? p_dad : p_cad;
          m_wd   = m_own ? p_dwd : p_cwd;
          m_done = e_idx + 2 + 1;
          m_act  = 1'b1;
        end
      end
      chk("rnd_cpu_ready", 32'(cpu_ready[1]), 32'(m_cr));
      chk("rnd_dbg_ready", 32'(dbg_ready[1]), 32'(m_dr));
      chk("rnd_err",       32'(err[1]),       32'(m_err));
      chk("rnd_cpu_rdata", cpu_rdata[1],      m_crd);
      chk("rnd_dbg_rdata", dbg_rdata[1],      m_drd);
      if (!cpu_req[1] || m_cr) begin
        if ($urandom_range(0, 2) != 0) begin
          cpu_req[1] = 1'b1; cpu_we[1] = 1'($urandom_range(0, 1));
          cpu_addr[1] = {24'd0, 6'($urandom_range(0, 63)),
                         ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
          cpu_wdata[1] = $urandom;
        end else begin
          cpu_req[1] = 1'b0;
        end
      end
      if (!dbg_req[1] || m_dr) begin
        if ($urandom_range(0, 2) != 0) begin
          dbg_req[1] = 1'b1; dbg_we[1] = 1'($urandom_range(0, 1));
          dbg_addr[1] = {24'd0, 6'($urandom_range(0, 63)),
                         ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
          dbg_wdata[1] = $urandom;
        end else begin
          dbg_req[1] = 1'b0;
        end
      end
    end
    cpu_req[1] = 1'b0; dbg_req[1] = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    for (int j = 0; j < 64; j++) chk($sformatf("rnd_mem%0d", j), mem[1][j], mmem[j]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 0, range 0..3: extra memory wait states per access.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 cpu_req  input  1  MEM-stage access request; held until cpu_ready.
REQ-005 cpu_we  input  1  CPU write when 1, read when 0.
REQ-006 cpu_addr  input  32  CPU byte address.
REQ-007 cpu_wdata  input  32  CPU store data.
REQ-008 cpu_ready  output  1  one-cycle completion pulse to CPU.
REQ-009 cpu_rdata  output  32  CPU load data; valid while cpu_ready=1.
REQ-010 cpu_stall  output  1  pipeline freeze = cpu_req & ~cpu_ready.
REQ-011 dbg_req, dbg_we, dbg_addr[31:0], dbg_wdata[31:0]  input  debug/loader port, same meaning as CPU port.
REQ-012 dbg_ready (1), dbg_rdata (32)  output  debug port completion and read data.
REQ-013 dm_addr  output  32  data-memory address.
REQ-014 dm_wdata  output  32  data-memory write data.
REQ-015 dm_we  output  1  data-memory write enable.
REQ-016 dm_rdata  input  32  data-memory combinational read data.
REQ-017 err  output  1  misaligned-access pulse, coincident with the ready pulse.

Function
REQ-018 FSM states: IDLE and BUSY only.
REQ-019 IDLE: request eligible if req=1 and that port's ready=0 in the same cycle.
REQ-020 IDLE, one eligible request: grant it. Latch we/addr/wdata and owner, load cnt=WAIT_CYCLES, next state BUSY.
REQ-021 IDLE, both eligible: grant the port not in last_owner (round-robin).
REQ-022 BUSY: dm_addr and dm_wdata driven from the latched values.
REQ-023 BUSY: dm_we = latched_we & (cnt==0) & aligned; a write occurs exactly once.
REQ-024 BUSY with cnt!=0: decrement cnt, stay in BUSY.
REQ-025 BUSY with cnt==0, on that edge:
- capture dm_rdata into the owner's rdata register;
- set owner's ready=1 for exactly one cycle;
- update last_owner;
- return to IDLE.
REQ-026 Latency from req sampled in IDLE to ready: WAIT_CYCLES+2 cycles. Back-to-back throughput: one access per WAIT_CYCLES+2 cycles.
REQ-027 Non-owner ready stays 0. Non-owner rdata holds its previous value.
REQ-028 Requester rule: deassert req, or present a new access, in the cycle its ready=1. The arbiter ignores that port for that cycle.
REQ-029 Misaligned access (latched addr[1:0]!=0), completed normally except:
- write suppressed;
- captured rdata=0;
- err=1 with ready.
REQ-030 IDLE outputs: dm_we=0, dm_addr=0, dm_wdata=0.
REQ-031 Request inputs changing during BUSY have no effect on the access in progress.

Reset
REQ-032 rst=0 forces asynchronously:
- state=IDLE, cnt=0, last_owner=DBG (CPU wins the first tie);
- all ready=0, err=0, dm_we=0;
- cpu_rdata=dbg_rdata=0.
REQ-033 Reset asserted mid-access aborts it: no write, no ready pulse. After release the arbiter restarts from IDLE.

Structure
REQ-034 Package dm_arb_pkg holds:
- state enum (IDLE, BUSY);
- owner enum (OWN_CPU, OWN_DBG);
- WAIT_CYCLES default;
- counter width (2).
REQ-035 One sub-module, rr_arb2: two-requester round-robin pick from (req_a, req_b, last_owner) to winner. Combinational.
REQ-036 All other logic (FSM, latches, counter, rdata capture) lives in dm_arbiter.

Verification
REQ-037 WAIT_CYCLES=0, CPU write addr 0x10 data 0xDEADBEEF, then read 0x10 -> dm_we high one cycle; cpu_ready 2 cycles after each req; cpu_rdata=0xDEADBEEF.
REQ-038 Both ports request same cycle after reset, held continuously -> grants CPU, DBG, CPU, DBG. cpu_stall=1 except in cpu_ready cycles.
REQ-039 WAIT_CYCLES=3, DBG read 0x20 -> dbg_ready exactly 5 cycles after req. cpu_ready stays 0.
REQ-040 CPU write addr 0x13 -> dm_we never 1; cpu_ready=1 and err=1 same cycle; memory unchanged.
REQ-041 WAIT_CYCLES=2, rst low during BUSY of a write -> dm_we=0 immediately; no ready pulse; memory unchanged. The next request after release completes normally.
REQ-042 CPU changes cpu_addr mid-BUSY -> access completes to the originally latched address.
